// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit.
package mem_stage_lsu_pkg;

  // Load/store funct3 encodings
  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  // Writeback source select
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_NONE = 2'b11;

  // Byte-enable patterns for a lane-0 access
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {StIdle, StReq, StDone} lsu_state_e;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} acc_size_e;

  // funct3[1:0] carries the size; undefined encodings fall back to a word access
  function automatic acc_size_e size_of(logic [1:0] f3_lo);
    unique case (f3_lo)
      2'b00:   return SzByte;
      2'b01:   return SzHalf;
      default: return SzWord;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack bus between the LSU (master) and the memory (slave).
interface mem_stage_lsu_if #(
  parameter int unsigned XLEN = 32
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module mem_stage_lsu_load_extend
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      iload_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select followed by extension according to funct3
  always_comb begin
    unique case (addr_lo_i)
      2'd0:    byte_lane = rdata_i[7:0];
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase
    half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (iload_i)
      LD_B:    data_o = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      LD_BU:   data_o = {{(XLEN-8){1'b0}}, byte_lane};
      LD_H:    data_o = {{(XLEN-16){half_lane[15]}}, half_lane};
      LD_HU:   data_o = {{(XLEN-16){1'b0}}, half_lane};
      LD_W:    data_o = rdata_i;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage: drives data-memory accesses, stalls while one is outstanding,
// and registers the MEM->WB bundle.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       ILoadM,
  input  logic [1:0]       WBSelM,
  input  logic             RegWEnM,
  input  logic             MemRWM,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  WriteDataM,
  input  logic [XLEN-1:0]  PCPlus4M,
  input  logic [WIDTH-1:0] rdM,
  mem_stage_lsu_if.master  dmem,
  output logic             stall_m,
  output logic             RegWEnW,
  output logic [WIDTH-1:0] rdW,
  output logic [XLEN-1:0]  WBDataW,
  output logic             MisalignW
);

  lsu_state_e      state_q, state_d;
  acc_size_e       size;
  logic            access, mis, go;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d, load_data, wb_data_d;

  logic            bus_we_q;
  logic [XLEN-1:0] bus_addr_q, bus_wdata_q, rdata_q;
  logic [3:0]      bus_be_q;

  // Access decode; misalignment only counts for real memory accesses
  always_comb begin
    size   = size_of(ILoadM[1:0]);
    access = (WBSelM == WB_MEM) | MemRWM;
    unique case (size)
      SzByte:  mis = 1'b0;
      SzHalf:  mis = access & ALUResultM[0];
      default: mis = access & (|ALUResultM[1:0]);
    endcase
    go = access & ~mis;
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    unique case (size)
      SzByte: begin
        be_d    = BE_BYTE << ALUResultM[1:0];
        wdata_d = {(XLEN/8){WriteDataM[7:0]}};
      end
      SzHalf: begin
        be_d    = BE_HALF << {ALUResultM[1], 1'b0};
        wdata_d = {(XLEN/16){WriteDataM[15:0]}};
      end
      default: begin
        be_d    = BE_WORD;
        wdata_d = WriteDataM;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // FSM next state; ack outside REQ is ignored
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (go) state_d = StReq;
      StReq:   if (dmem.dmem_ack) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; req decodes straight from state so reset drops it at once
  always_comb begin
    dmem.dmem_req   = (state_q == StReq);
    dmem.dmem_we    = bus_we_q;
    dmem.dmem_addr  = bus_addr_q;
    dmem.dmem_be    = bus_be_q;
    dmem.dmem_wdata = bus_wdata_q;
    stall_m         = go & (state_q != StDone);
  end

  // Bus fields latched on access launch, read data captured on ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      if (state_q == StIdle && go) begin
        bus_we_q    <= MemRWM;
        bus_addr_q  <= {ALUResultM[XLEN-1:2], 2'b00};
        bus_be_q    <= be_d;
        bus_wdata_q <= wdata_d;
      end
      if (state_q == StReq && dmem.dmem_ack) rdata_q <= dmem.dmem_rdata;
    end
  end

  mem_stage_lsu_load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .rdata_i  (rdata_q),
    .addr_lo_i(ALUResultM[1:0]),
    .iload_i  (ILoadM),
    .data_o   (load_data)
  );

  // Writeback source select
  always_comb begin
    unique case (WBSelM)
      WB_ALU:  wb_data_d = ALUResultM;
      WB_MEM:  wb_data_d = load_data;
      WB_PC4:  wb_data_d = PCPlus4M;
      default: wb_data_d = '0;
    endcase
  end

  // MEM->WB register; a stall inserts a bubble and holds rd/data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWEnW   <= 1'b0;
      rdW       <= '0;
      WBDataW   <= '0;
      MisalignW <= 1'b0;
    end else if (stall_m) begin
      RegWEnW   <= 1'b0;
      MisalignW <= 1'b0;
    end else begin
      RegWEnW   <= RegWEnM & ~mis;
      MisalignW <= mis;
      rdW       <= rdM;
      WBDataW   <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: random and directed instructions, a memory
// responder with random ack latency, and a WB monitor.
module tb_mem_stage_lsu;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned WIDTH = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       ILoadM;
  logic [1:0]       WBSelM;
  logic             RegWEnM, MemRWM;
  logic [XLEN-1:0]  ALUResultM, WriteDataM, PCPlus4M;
  logic [WIDTH-1:0] rdM;
  logic             stall_m, RegWEnW, MisalignW;
  logic [WIDTH-1:0] rdW;
  logic [XLEN-1:0]  WBDataW;

  mem_stage_lsu_if #(.XLEN(XLEN)) dmem ();

  mem_stage_lsu #(
    .XLEN (XLEN),
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ILoadM    (ILoadM),
    .WBSelM    (WBSelM),
    .RegWEnM   (RegWEnM),
    .MemRWM    (MemRWM),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .PCPlus4M  (PCPlus4M),
    .rdM       (rdM),
    .dmem      (dmem),
    .stall_m   (stall_m),
    .RegWEnW   (RegWEnW),
    .rdW       (rdW),
    .WBDataW   (WBDataW),
    .MisalignW (MisalignW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        regwen;
    logic        mis;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          chk_data;
    int          stall;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;
  bit resp_en     = 1'b0;
  int late_req    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: access width in bytes from funct3
  function automatic int unsigned acc_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int unsigned n, off;
    logic [31:0] mask, v;
    n = acc_bytes(f3);
    if (n == 4) return word;
    off  = (addr % 4) - ((addr % 4) % n);
    mask = (32'h1 << (8 * n)) - 1;
    v    = (word >> (8 * off)) & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Drive one instruction, record expectations, hold it until the stall lifts
  task automatic issue(input logic [2:0] f3, input logic [1:0] wbsel, input logic regwen,
                       input logic memrw, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] pc4, input logic [4:0] rd, input int delay,
                       input logic [31:0] rdata);
    wb_exp_t     w;
    bus_exp_t    b;
    int unsigned n, off;
    bit          access, mis;
    int          waitc;
    n      = acc_bytes(f3);
    off    = (alu % 4) - ((alu % 4) % n);
    access = (wbsel == 2'b01) || memrw;
    mis    = access && ((alu % n) != 0);
    w.regwen   = regwen && !mis;
    w.mis      = mis;
    w.rd       = rd;
    w.chk_data = !(mis && wbsel == 2'b01);
    case (wbsel)
      2'b00:   w.data = alu;
      2'b01:   w.data = load_model(f3, alu, rdata);
      2'b10:   w.data = pc4;
      default: w.data = 32'h0;
    endcase
    w.stall = (access && !mis) ? delay + 2 : 0;
    wb_q.push_back(w);
    if (access && !mis) begin
      b.we    = memrw;
      b.addr  = alu - (alu % 4);
      b.be    = 4'(((1 << n) - 1) << off);
      b.wdata = (n == 1) ? (wd & 32'hff) * 32'h01010101 :
                (n == 2) ? (wd & 32'hffff) * 32'h00010001 : wd;
      b.rdata = rdata;
      b.delay = delay;
      bus_q.push_back(b);
    end
    ILoadM     = f3;
    WBSelM     = wbsel;
    RegWEnM    = regwen;
    MemRWM     = memrw;
    ALUResultM = alu;
    WriteDataM = wd;
    PCPlus4M   = pc4;
    rdM        = rd;
    waitc      = 0;
    forever begin
      @(negedge clk);
      if (!stall_m) break;
      waitc++;
      if (waitc > 40) begin
        miscompares++;
        $display("FAIL stall_timeout: stall_m still 1 after %0d cycles, expected release", waitc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "stall never released");
      end
    end
    @(posedge clk);
    #2;
  endtask

  // WB monitor: bubbles while stalled, pops the scoreboard on each retire
  wb_exp_t mon_w;
  bit      mon_s, mon_en_s;
  int      mon_stall_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      mon_s    = stall_m;
      mon_en_s = mon_en;
      @(posedge clk);
      #1;
      if (mon_en_s) begin
        if (mon_s) begin
          mon_stall_cnt++;
          check("bubble_regwen", 32'(RegWEnW), 32'h0);
          check("bubble_misalign", 32'(MisalignW), 32'h0);
        end else if (wb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_retire: retire with empty scoreboard, expected none");
        end else begin
          mon_w = wb_q.pop_front();
          check("wb_regwen", 32'(RegWEnW), 32'(mon_w.regwen));
          check("wb_misalign", 32'(MisalignW), 32'(mon_w.mis));
          check("wb_rd", 32'(rdW), 32'(mon_w.rd));
          if (mon_w.chk_data) check("wb_data", WBDataW, mon_w.data);
          check("stall_cycles", 32'(mon_stall_cnt), 32'(mon_w.stall));
          mon_stall_cnt = 0;
        end
      end
    end
  end

  // Memory responder: checks each request, acks after its planned delay,
  // and throws in stray acks while no request is pending
  bus_exp_t cur;
  bit       busy = 1'b0;
  int       cnt = 0;
  int       late_done = 0;
  initial begin
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem.dmem_ack = 1'b0;
      if (late_req != late_done) begin
        late_done++;
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = $urandom;
      end else if (resp_en) begin
        if (busy) begin
          check("req_held", 32'(dmem.dmem_req), 32'h1);
          check("addr_stable", dmem.dmem_addr, cur.addr);
        end else if (dmem.dmem_req) begin
          if (bus_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_req: dmem_req=1 addr=0x%08h, expected no request",
                     dmem.dmem_addr);
          end else begin
            cur  = bus_q.pop_front();
            busy = 1'b1;
            cnt  = cur.delay;
            check("bus_we", 32'(dmem.dmem_we), 32'(cur.we));
            check("bus_addr", dmem.dmem_addr, cur.addr);
            if (cur.we) begin
              check("bus_be", 32'(dmem.dmem_be), 32'(cur.be));
              check("bus_wdata", dmem.dmem_wdata, cur.wdata);
            end
          end
        end
        if (busy) begin
          if (cnt == 0) begin
            dmem.dmem_ack   = 1'b1;
            dmem.dmem_rdata = cur.rdata;
            busy            = 1'b0;
          end else begin
            cnt--;
          end
        end else if (!dmem.dmem_req && $urandom_range(0, 5) == 0) begin
          dmem.dmem_ack   = 1'b1;
          dmem.dmem_rdata = $urandom;
        end
      end
    end
  end

  initial begin
    int waitc;
    logic [31:0] alu;
    rst        = 1'b0;
    ILoadM     = '0;
    WBSelM     = '0;
    RegWEnM    = 1'b0;
    MemRWM     = 1'b0;
    ALUResultM = '0;
    WriteDataM = '0;
    PCPlus4M   = '0;
    rdM        = '0;
    #3;
    check("rst_req", 32'(dmem.dmem_req), 32'h0);
    check("rst_we", 32'(dmem.dmem_we), 32'h0);
    check("rst_addr", dmem.dmem_addr, 32'h0);
    check("rst_be", 32'(dmem.dmem_be), 32'h0);
    check("rst_wdata", dmem.dmem_wdata, 32'h0);
    check("rst_regwen", 32'(RegWEnW), 32'h0);
    check("rst_rd", 32'(rdW), 32'h0);
    check("rst_wbdata", WBDataW, 32'h0);
    check("rst_misalign", 32'(MisalignW), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    mon_en  = 1'b1;
    resp_en = 1'b1;

    // Directed cases
    issue(3'b010, 2'b01, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 5'd5, 3, 32'hDEADBEEF);
    issue(3'b000, 2'b01, 1'b1, 1'b0, 32'h103, 32'h0, 32'h0, 5'd6, 0, 32'h80000000);
    issue(3'b100, 2'b01, 1'b1, 1'b0, 32'h103, 32'h0, 32'h0, 5'd7, 1, 32'h80000000);
    issue(3'b101, 2'b01, 1'b1, 1'b0, 32'h102, 32'h0, 32'h0, 5'd8, 2, 32'h80011234);
    issue(3'b001, 2'b00, 1'b0, 1'b1, 32'h202, 32'h1234ABCD, 32'h0, 5'd0, 1, 32'h0);
    issue(3'b010, 2'b01, 1'b1, 1'b0, 32'h101, 32'h0, 32'h0, 5'd9, 0, 32'h0);
    issue(3'b000, 2'b00, 1'b1, 1'b0, 32'h5, 32'h0, 32'h0, 5'd10, 0, 32'h0);
    issue(3'b000, 2'b10, 1'b1, 1'b0, 32'h7, 32'h0, 32'h44, 5'd11, 0, 32'h0);
    issue(3'b000, 2'b00, 1'b0, 1'b1, 32'h301, 32'h000000A5, 32'h0, 5'd0, 0, 32'h0);
    issue(3'b001, 2'b00, 1'b0, 1'b1, 32'h303, 32'h0000BEEF, 32'h0, 5'd0, 0, 32'h0);

    // Random mix
    for (int i = 0; i < 80; i++) begin
      alu = $urandom;
      if ($urandom_range(0, 1) == 0) alu[1:0] = 2'b00;
      issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), alu, $urandom, $urandom, 5'($urandom_range(0, 31)),
            int'($urandom_range(0, 4)), $urandom);
    end

    mon_en     = 1'b0;
    WBSelM     = 2'b00;
    MemRWM     = 1'b0;
    RegWEnM    = 1'b0;
    check("wb_queue_drained", 32'(wb_q.size()), 32'h0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'h0);

    // Reset while a load is waiting for its ack
    resp_en    = 1'b0;
    ILoadM     = 3'b010;
    WBSelM     = 2'b01;
    RegWEnM    = 1'b1;
    ALUResultM = 32'h300;
    rdM        = 5'd7;
    waitc      = 0;
    do begin
      @(negedge clk);
      waitc++;
    end while (!dmem.dmem_req && waitc < 10);
    check("rstreq_entered", 32'(dmem.dmem_req), 32'h1);
    #1 rst = 1'b0;
    #1;
    check("rstreq_req", 32'(dmem.dmem_req), 32'h0);
    check("rstreq_regwen", 32'(RegWEnW), 32'h0);
    check("rstreq_rd", 32'(rdW), 32'h0);
    check("rstreq_wbdata", WBDataW, 32'h0);
    check("rstreq_misalign", 32'(MisalignW), 32'h0);
    check("rstreq_addr", dmem.dmem_addr, 32'h0);
    WBSelM  = 2'b00;
    RegWEnM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    late_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("late_ack_req", 32'(dmem.dmem_req), 32'h0);
      check("late_ack_stall", 32'(stall_m), 32'h0);
    end
    check("late_ack_regwen", 32'(RegWEnW), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
